// File: rtl/vault_access_controller.sv
// Vault door controller: time-locked unlock, bounded open window, latched alarm.
// Latency: all outputs are registered and reflect the inputs sampled on the previous clk_2 edge.
// Backpressure: none; every input is level-sampled on each clock edge.
module vault_access_controller #(
  parameter int unsigned DELAY_CYCLES = 4,  // legal 1..15
  parameter int unsigned OPEN_CYCLES  = 8   // legal 1..15
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       door_open,
  input  logic       business_hours,
  input  logic       manager_key,
  input  logic       unlock_req,
  input  logic       alarm_clear,
  output logic       lock_engaged,
  output logic       alarm,
  output logic [1:0] state,
  output logic [3:0] count,
  output logic [3:0] alarm_events
);

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_DELAY  = 2'd1,
    ST_OPEN   = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  localparam logic [3:0] DELAY_LOAD = 4'(DELAY_CYCLES);
  localparam logic [3:0] OPEN_LOAD  = 4'(OPEN_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] events_q, events_d;
  logic       lock_q, lock_d;
  logic       alarm_q, alarm_d;

  // Next-state and counter rules; earlier conditions in each state take priority.
  always_comb begin
    state_d = state_q;
    count_d = 4'd0;
    unique case (state_q)
      ST_LOCKED: begin
        if (door_open) begin
          state_d = ST_ALARM;             // forced entry
        end else if (unlock_req && business_hours) begin
          state_d = ST_DELAY;
          count_d = DELAY_LOAD;
        end
      end
      ST_DELAY: begin
        if (door_open) begin
          state_d = ST_ALARM;
        end else if (!business_hours) begin
          state_d = ST_LOCKED;            // abort outside opening hours
        end else if (count_q == 4'd1) begin
          state_d = ST_OPEN;
          count_d = OPEN_LOAD;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      ST_OPEN: begin
        // Window closes early when hours end; an open door at close is an alarm.
        if (!business_hours || count_q == 4'd1) begin
          state_d = door_open ? ST_ALARM : ST_LOCKED;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      ST_ALARM: begin
        // Only a manager can clear, and never while the door is still open.
        if (manager_key && alarm_clear && !door_open) begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  // Alarm entry counter saturates so a burst of events cannot wrap back to zero.
  always_comb begin
    events_d = events_q;
    if (state_d == ST_ALARM && state_q != ST_ALARM && events_q != 4'd15) begin
      events_d = events_q + 4'd1;
    end
  end

  // Moore decodes computed from the next state so they register alongside it.
  always_comb begin
    lock_d  = (state_d != ST_OPEN);
    alarm_d = (state_d == ST_ALARM);
  end

  // State register with synchronous active-low reset overriding every state.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state_q  <= ST_LOCKED;
      count_q  <= 4'd0;
      events_q <= 4'd0;
      lock_q   <= 1'b1;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      events_q <= events_d;
      lock_q   <= lock_d;
      alarm_q  <= alarm_d;
    end
  end

  assign state        = state_q;
  assign count        = count_q;
  assign alarm_events = events_q;
  assign lock_engaged = lock_q;
  assign alarm        = alarm_q;

endmodule

// File: doc/vault_access_controller.md
Name: vault_access_controller

Overview:
Sequential controller for the bank-agency vault door. It replaces the purely combinational vault alarm with a time-locked unlock sequence, a bounded open window, and a latched alarm that needs a manager to clear. It sits behind the top-level switch inputs and drives the lock solenoid and alarm LEDs. It is clocked by clk_2.

Parameters:
DELAY_CYCLES, 4, time-lock length in clk_2 cycles between an accepted unlock request and the lock releasing; legal range 1..15.
OPEN_CYCLES, 8, length of the open window in cycles; legal range 1..15.

Ports:
clk_2  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous reset, active-low; sampled on posedge clk_2.
door_open  input  1  door sensor; 1 = door physically open.
business_hours  input  1  1 = agency within opening hours.
manager_key  input  1  manager key inserted.
unlock_req  input  1  unlock request from the teller console, level-sampled.
alarm_clear  input  1  alarm acknowledge; effective only together with manager_key.
lock_engaged  output  1  1 = solenoid locked.
alarm  output  1  1 = alarm active.
state  output  2  current FSM state, encoded for LED display.
count  output  4  remaining cycles in DELAY or OPEN; 0 otherwise.
alarm_events  output  4  saturating count of entries into ALARM.

Behaviour:
- Reset: when reset=0 at a posedge, the block takes state=LOCKED(2'd0), count=0, lock_engaged=1, alarm=0, alarm_events=0. Reset overrides all other inputs in every state, including mid-DELAY, mid-OPEN and ALARM.
- Outputs: state, count and alarm_events are registered. lock_engaged and alarm are Moore decodes of state:
  - lock_engaged=0 only in OPEN.
  - alarm=1 only in ALARM.
- State encodings: LOCKED=0, DELAY=1, OPEN=2, ALARM=3. Within each state the transition rules below are checked in the order listed; the first match wins.
- LOCKED:
  - door_open=1 -> ALARM (forced entry).
  - else unlock_req=1 and business_hours=1 -> DELAY, count<=DELAY_CYCLES.
  - else stay in LOCKED, count=0.
- DELAY:
  - door_open=1 -> ALARM, count<=0.
  - else business_hours=0 -> LOCKED, count<=0 (abort).
  - else count==1 -> OPEN, count<=OPEN_CYCLES.
  - else count<=count-1.
  - DELAY therefore lasts exactly DELAY_CYCLES cycles. unlock_req is ignored while in DELAY.
- OPEN:
  - business_hours=0: if door_open=1 -> ALARM, else -> LOCKED. count<=0 in both cases.
  - else count==1: if door_open=1 -> ALARM (door propped), else -> LOCKED. count<=0 in both cases.
  - else count<=count-1.
  - The door may open and close freely inside the window. The lock re-engages at window end.
- ALARM:
  - manager_key=1 and alarm_clear=1 and door_open=0 -> LOCKED.
  - otherwise stay in ALARM. count=0 throughout.
  - alarm_clear without manager_key has no effect. Clearing with the door still open is refused.
- alarm_events:
  - Increments by 1 on every transition into ALARM from any other state.
  - Saturates at 15; does not wrap.
  - Cleared only by reset.
  - Remaining in ALARM does not increment it.
- count arithmetic: 4-bit unsigned. It never underflows, because count==1 is the exit condition. Parameter values of 0 or above 15 are illegal.
- Simultaneous events: on the same edge, door_open outranks unlock_req in LOCKED and outranks the abort in DELAY. unlock_req together with business_hours=0 in LOCKED has no effect.

Test Plan:
1. Reset sequence: hold reset=0 for 2 cycles with door_open=1 and unlock_req=1 -> state=0, lock_engaged=1, alarm=0, count=0, alarm_events=0. Release reset with door_open=0 -> remains LOCKED.
2. Normal unlock (business_hours=1, unlock_req pulsed 1 cycle):
   - state=1, with count 4,3,2,1 over 4 cycles.
   - Then state=2, lock_engaged=0, count 8..1.
   - Open and close the door during the window.
   - Door closed at count==1 -> LOCKED, lock_engaged=1, alarm_events=0.
3. Forced entry: in LOCKED, set door_open=1 -> next cycle state=3, alarm=1, alarm_events=1.
   - alarm_clear=1 alone -> stays in ALARM.
   - manager_key=1 and alarm_clear=1 with door_open=1 -> stays in ALARM.
   - Close the door -> LOCKED next cycle.
4. Propped door: complete DELAY, enter OPEN, hold door_open=1 through count==1 -> ALARM, alarm_events increments by 1.
5. Aborts:
   - Drop business_hours at DELAY count=2 -> LOCKED, count=0.
   - Drop business_hours in OPEN with the door closed -> LOCKED.
   - Drop business_hours in OPEN with the door open -> ALARM.
   - Assert reset=0 mid-OPEN -> LOCKED, lock_engaged=1 next cycle.
6. Saturation: trigger 17 forced-entry alarm/clear cycles -> alarm_events reads 15 after the 15th and stays 15.
